hit_arbiter: RTL and testbench
==============================

Name: hit_arbiter

Overview:
- Round-robin arbiter that merges hit streams from NREQ layer FIFOs (first-word-fall-through) onto one shared hit bus.
- The shared bus feeds the downstream hit register bank. DOUT_CE is the register load enable; DOUT_ID selects the destination layer register.
- Tracks per-requester end-of-event (EE) markers. Emits one merged EE word carrying the event hit count once every requester has delivered its EE.

Parameters:
- HITBITS, 10, width of a hit word and of the EE hit count.
- NREQ, 4, number of requesters (layers), 2..8.
- IDBITS, 2, width of DOUT_ID; must satisfy 2^IDBITS >= NREQ.

Ports:
- CLOCK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  NREQ  requester i has a word at its FIFO head.
- REQ_EE  in  NREQ  head word of requester i is an EE marker; qualified by REQ_VALID[i].
- REQ_DIN  in  NREQ*HITBITS  head words; requester i occupies bits [i*HITBITS +: HITBITS].
- REQ_ACK  out  NREQ  one-hot read strobe; combinational, pops the FIFO head at the same edge.
- HOLD  in  1  downstream back-pressure.
- DOUT  out  HITBITS  registered hit word, or the event hit count on an EE word.
- DOUT_ID  out  IDBITS  registered source requester index; 0 on an EE word.
- DOUT_CE  out  1  registered one-cycle strobe: DOUT is a valid hit.
- DOUT_EE  out  1  registered one-cycle strobe: merged end-of-event.

Behaviour:
- Reset (RESET=1 at an edge): DOUT=0, DOUT_ID=0, DOUT_CE=0, DOUT_EE=0, rotation pointer=0, ee_seen=0, hit count=0. REQ_ACK=0 during any cycle with RESET=1.
- Reset mid-event discards partial EE state and the count. Words already acked are lost.
- Eligible requester i: REQ_VALID[i]=1 and ee_seen[i]=0.
- At most one REQ_ACK bit is high per cycle. It goes to the first eligible index searching from the rotation pointer upward, wrapping modulo NREQ.
- After a grant to index g, the pointer becomes (g+1) mod NREQ. The pointer is unchanged when there is no grant.
- No grant, and therefore REQ_ACK=0, when HOLD=1, ee_all=1 or RESET=1.
- Granted data word (REQ_EE[g]=0): at the next edge, DOUT=REQ_DIN[g], DOUT_ID=g, DOUT_CE=1, DOUT_EE=0. The hit count increments, saturating at 2^HITBITS-1.
- Granted EE word (REQ_EE[g]=1): the marker is popped and ee_seen[g] is set at the next edge. The bus is not driven: DOUT_CE=0 and DOUT/DOUT_ID hold.
- A requester with ee_seen set is masked until the merged EE is emitted. It receives no further ACKs, so words of the next event wait in its FIFO.
- Latency: one cycle from ACK to DOUT_CE. Sustained throughput is one word per cycle.
- States: ARB (normal granting) and EMIT (ee_all=1, i.e. the registered ee_seen is all ones).
- In EMIT with HOLD=0: at the next edge DOUT=hit count, DOUT_ID=0, DOUT_EE=1, DOUT_CE=0. ee_seen and the count clear at that same edge, and the state returns to ARB.
- In EMIT with HOLD=1: the block waits, with DOUT_EE=0.
- HOLD=1 in any state: DOUT_CE=0 and DOUT_EE=0 next cycle, and DOUT/DOUT_ID hold. Nothing is lost because no ACK was issued.
- DOUT_CE and DOUT_EE are never high together.
- An event with zero hits on every requester emits EE with DOUT=0.

Test Plan:
- Reset: RESET=1 for 2 cycles with all REQ_VALID=1 -> REQ_ACK=0 throughout; after release DOUT=0, DOUT_CE=0, DOUT_EE=0, and the first grant goes to requester 0.
- Fairness: all 4 requesters continuously valid with data -> DOUT_ID sequence 0,1,2,3,0,1 and DOUT_CE high every cycle; each REQ_ACK bit fires once per 4 cycles.
- Back-pressure: HOLD=1 for 3 cycles after a grant to 1 -> REQ_ACK=0 and DOUT_CE=0 for 3 cycles with DOUT held; after release the next grant goes to 2.
- Event merge: req0 sends 0x011, 0x022, then EE; req1..3 each send 1 hit then EE -> 5 DOUT_CE pulses, then a single DOUT_EE with DOUT=5 and DOUT_ID=0. No ACK reaches req0's next-event word before that DOUT_EE.
- Masking: req2 reaches EE early while req0 still streams 6 hits -> req2 receives no ACK until after DOUT_EE, which carries the total of all hits.
- Saturation and reset: 1030 hits in one event with HITBITS=10 -> DOUT_EE carries 1023. RESET asserted with ee_seen=0b0101 and count 7 -> the following event's DOUT_EE carries only that event's hit count.

Source files
------------

// File: rtl/hit_arbiter.sv
// hit_arbiter: round-robin merge of NREQ first-word-fall-through hit FIFOs
// onto one registered hit bus, with end-of-event (EE) merging.
//   CLOCK, RESET       clock (rising edge), synchronous active-high reset
//   REQ_VALID/EE/DIN   per-requester FIFO head: valid, EE marker, hit word
//   REQ_ACK            one-hot combinational pop strobe
//   HOLD               downstream back-pressure; blocks grants and EE emission
//   DOUT, DOUT_ID      registered hit word and source index (EE: count and 0)
//   DOUT_CE, DOUT_EE   registered one-cycle hit / merged-EE strobes
module hit_arbiter #(
  parameter int HITBITS = 10,
  parameter int NREQ    = 4,
  parameter int IDBITS  = 2
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic [NREQ-1:0]           REQ_VALID,
  input  logic [NREQ-1:0]           REQ_EE,
  input  logic [NREQ*HITBITS-1:0]   REQ_DIN,
  output logic [NREQ-1:0]           REQ_ACK,
  input  logic                      HOLD,
  output logic [HITBITS-1:0]        DOUT,
  output logic [IDBITS-1:0]         DOUT_ID,
  output logic                      DOUT_CE,
  output logic                      DOUT_EE
);

  typedef enum logic {ARB, EMIT} state_t;

  state_t              state, state_next;
  logic [IDBITS-1:0]   ptr;
  logic [NREQ-1:0]     ee_seen;
  logic [HITBITS-1:0]  count;

  logic                found;
  logic [IDBITS-1:0]   gidx;
  logic [NREQ-1:0]     gonehot;
  logic                gee;
  logic [HITBITS-1:0]  gdin;
  logic                grant;
  logic                emit;

  // Rotating priority done as two passes so every index is a loop constant:
  // first eligible at or above ptr, otherwise the lowest eligible overall.
  always_comb begin
    found   = 1'b0;
    gidx    = '0;
    gonehot = '0;
    gee     = 1'b0;
    gdin    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && REQ_VALID[i] && !ee_seen[i] && i >= 32'(ptr)) begin
        found      = 1'b1;
        gidx       = IDBITS'(i);
        gonehot[i] = 1'b1;
        gee        = REQ_EE[i];
        gdin       = REQ_DIN[i*HITBITS +: HITBITS];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && REQ_VALID[i] && !ee_seen[i]) begin
        found      = 1'b1;
        gidx       = IDBITS'(i);
        gonehot[i] = 1'b1;
        gee        = REQ_EE[i];
        gdin       = REQ_DIN[i*HITBITS +: HITBITS];
      end
    end
  end

  // State register
  always_ff @(posedge CLOCK) begin
    if (RESET) state <= ARB;
    else       state <= state_next;
  end

  // Next state: EMIT exactly while the registered ee_seen is all ones
  always_comb begin
    state_next = state;
    case (state)
      ARB:  if (grant && gee && ((ee_seen | gonehot) == '1)) state_next = EMIT;
      EMIT: if (!HOLD) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // Outputs of the FSM: grant / emit qualifiers and the pop strobe
  always_comb begin
    grant   = found && (state == ARB) && !HOLD && !RESET;
    emit    = (state == EMIT) && !HOLD;
    REQ_ACK = grant ? gonehot : '0;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ptr     <= '0;
      ee_seen <= '0;
      count   <= '0;
      DOUT    <= '0;
      DOUT_ID <= '0;
      DOUT_CE <= 1'b0;
      DOUT_EE <= 1'b0;
    end else begin
      DOUT_CE <= 1'b0;
      DOUT_EE <= 1'b0;
      if (grant) begin
        if (32'(gidx) == NREQ - 1) ptr <= '0;
        else                       ptr <= gidx + 1'b1;
        if (gee) begin
          ee_seen <= ee_seen | gonehot;
        end else begin
          DOUT    <= gdin;
          DOUT_ID <= gidx;
          DOUT_CE <= 1'b1;
          if (count != '1) count <= count + 1'b1;
        end
      end
      if (emit) begin
        DOUT    <= count;
        DOUT_ID <= '0;
        DOUT_EE <= 1'b1;
        ee_seen <= '0;
        count   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hit_arbiter.sv
module tb_hit_arbiter;

  localparam int HITBITS = 10;
  localparam int NREQ    = 4;
  localparam int IDBITS  = 2;

  logic                    CLOCK;
  logic                    RESET;
  logic [NREQ-1:0]         REQ_VALID;
  logic [NREQ-1:0]         REQ_EE;
  logic [NREQ*HITBITS-1:0] REQ_DIN;
  logic [NREQ-1:0]         REQ_ACK;
  logic                    HOLD;
  logic [HITBITS-1:0]      DOUT;
  logic [IDBITS-1:0]       DOUT_ID;
  logic                    DOUT_CE;
  logic                    DOUT_EE;

  hit_arbiter #(.HITBITS(HITBITS), .NREQ(NREQ), .IDBITS(IDBITS)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_EE(REQ_EE),
    .REQ_DIN(REQ_DIN), .REQ_ACK(REQ_ACK), .HOLD(HOLD), .DOUT(DOUT),
    .DOUT_ID(DOUT_ID), .DOUT_CE(DOUT_CE), .DOUT_EE(DOUT_EE)
  );

  typedef struct packed {
    logic               ee;
    logic [HITBITS-1:0] data;
    logic [IDBITS-1:0]  id;
  } exp_t;

  exp_t             exp_q[$];
  logic [HITBITS:0] fq[NREQ][$];   // requester FIFO models: {ee, word}
  int               checks   = 0;
  int               failures = 0;
  int               mon_ee   = 0;
  logic [NREQ-1:0]  last_ack;
  logic             rst, hold;
  bit               mask_arm = 0;
  bit               mask2    = 0;
  int               mask_base = 0;

  initial begin
    CLOCK = 0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void exp_hit(input int d, input int id);
    exp_t e;
    e.ee = 1'b0; e.data = HITBITS'(d); e.id = IDBITS'(id);
    exp_q.push_back(e);
  endfunction

  function automatic void exp_ee(input int cnt);
    exp_t e;
    e.ee = 1'b1; e.data = HITBITS'(cnt); e.id = '0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_word(input int r, input bit ee, input int d);
    fq[r].push_back({ee, HITBITS'(d)});
  endfunction

  function automatic bit busy();
    bit b = exp_q.size() != 0;
    for (int i = 0; i < NREQ; i++) if (fq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a strobe
  always @(negedge CLOCK) begin
    exp_t e;
    if (DOUT_CE === 1'b1 || DOUT_EE === 1'b1) begin
      check(!(DOUT_CE && DOUT_EE), "ce_ee_exclusive", {DOUT_CE, DOUT_EE}, 0);
      check(exp_q.size() != 0, "unexpected_output", DOUT, 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(DOUT_EE == e.ee, "out_kind_ee", DOUT_EE, e.ee);
        check(DOUT == e.data, "out_dout", DOUT, e.data);
        check(DOUT_ID == e.id, "out_dout_id", DOUT_ID, e.id);
      end
      if (DOUT_EE) mon_ee++;
    end
  end

  // One clock: drive FIFO heads at the negedge, sample the ack, pop acked heads
  task automatic step();
    for (int i = 0; i < NREQ; i++) begin
      REQ_VALID[i] = fq[i].size() != 0;
      REQ_EE[i]    = (fq[i].size() != 0) ? fq[i][0][HITBITS] : 1'b0;
      REQ_DIN[i*HITBITS +: HITBITS] = (fq[i].size() != 0) ? fq[i][0][HITBITS-1:0] : '0;
    end
    RESET = rst;
    HOLD  = hold;
    #1;
    last_ack = REQ_ACK;
    check($countones(last_ack) <= 1, "ack_onehot", last_ack, 0);
    if (mask2 && mon_ee == mask_base)
      check(last_ack[2] == 1'b0, "req2_masked", last_ack, 0);
    for (int i = 0; i < NREQ; i++) begin
      if (last_ack[i]) begin
        check(fq[i].size() != 0, "ack_on_empty", i, 0);
        if (fq[i].size() != 0) begin
          if (i == 2 && mask_arm && fq[i][0][HITBITS]) mask2 = 1;
          void'(fq[i].pop_front());
        end
      end
    end
    @(negedge CLOCK);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) begin
      step();
      check(last_ack == '0, "ack_in_reset", last_ack, 0);
    end
    rst = 0;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    check(!busy(), name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; hold = 0;
    RESET = 1; HOLD = 0;
    REQ_VALID = '0; REQ_EE = '0; REQ_DIN = '0;
    @(negedge CLOCK);

    // Reset with all requesters valid, then fairness 0,1,2,3,0,1,2,3
    for (int i = 0; i < NREQ; i++) begin
      push_word(i, 0, 'h100 + i);
      push_word(i, 0, 'h104 + i);
    end
    for (int k = 0; k < 8; k++) exp_hit('h100 + k, k % 4);
    do_reset(2);
    check(DOUT == '0, "rst_dout", DOUT, 0);
    check(DOUT_CE == 1'b0, "rst_ce", DOUT_CE, 0);
    check(DOUT_EE == 1'b0, "rst_ee", DOUT_EE, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check(last_ack == NREQ'(1 << (k % 4)), "fair_ack", last_ack, 1 << (k % 4));
      check(DOUT_CE == 1'b1, "fair_ce", DOUT_CE, 1);
    end
    drain(20, "t1_drain");

    // Back-pressure after a grant to requester 1
    push_word(1, 0, 'h0A1);
    push_word(2, 0, 'h0A2);
    exp_hit('h0A1, 1);
    exp_hit('h0A2, 2);
    step();
    check(last_ack == 4'b0010, "bp_first_ack", last_ack, 2);
    hold = 1;
    repeat (3) begin
      step();
      check(last_ack == '0, "bp_ack_held", last_ack, 0);
      check(DOUT_CE == 1'b0, "bp_ce_held", DOUT_CE, 0);
      check(DOUT == 10'h0A1, "bp_dout_held", DOUT, 'h0A1);
      check(DOUT_ID == 2'd1, "bp_id_held", DOUT_ID, 1);
    end
    hold = 0;
    step();
    check(last_ack == 4'b0100, "bp_next_ack", last_ack, 4);
    drain(20, "t2_drain");

    // Event merge: 5 hits then one EE carrying 5; next-event word after it
    do_reset(1);
    push_word(0, 0, 'h011); push_word(0, 0, 'h022); push_word(0, 1, 0); push_word(0, 0, 'h033);
    push_word(1, 0, 'h111); push_word(1, 1, 0);
    push_word(2, 0, 'h122); push_word(2, 1, 0);
    push_word(3, 0, 'h133); push_word(3, 1, 0);
    exp_hit('h011, 0); exp_hit('h111, 1); exp_hit('h122, 2); exp_hit('h133, 3);
    exp_hit('h022, 0); exp_ee(5); exp_hit('h033, 0);
    drain(40, "t3_drain");

    // Masking: req2 EE early, req0 streams 6 hits
    do_reset(1);
    mask_arm = 1; mask_base = mon_ee;
    for (int k = 0; k < 6; k++) push_word(0, 0, 'h200 + k);
    push_word(0, 1, 0);
    push_word(1, 1, 0);
    push_word(2, 1, 0); push_word(2, 0, 'h2F0);
    push_word(3, 1, 0);
    for (int k = 0; k < 6; k++) exp_hit('h200 + k, 0);
    exp_ee(6);
    exp_hit('h2F0, 2);
    drain(40, "t4_drain");
    check(mask2 == 1'b1, "t4_mask_armed", mask2, 1);
    mask_arm = 0; mask2 = 0;

    // Saturation: 1030 hits in one event -> count 1023
    do_reset(1);
    for (int n = 0; n < 1030; n++) begin
      push_word(0, 0, n & 'h3FF);
      exp_hit(n & 'h3FF, 0);
    end
    push_word(0, 1, 0);
    push_word(1, 1, 0); push_word(2, 1, 0); push_word(3, 1, 0);
    exp_ee(1023);
    drain(1100, "t5_drain");

    // Reset mid-event with ee_seen=0101 and count 7
    do_reset(1);
    for (int k = 0; k < 4; k++) push_word(0, 0, 'h3A0 + k);
    push_word(0, 1, 0);
    for (int k = 0; k < 3; k++) push_word(2, 0, 'h3B0 + k);
    push_word(2, 1, 0);
    exp_hit('h3A0, 0); exp_hit('h3B0, 2); exp_hit('h3A1, 0); exp_hit('h3B1, 2);
    exp_hit('h3A2, 0); exp_hit('h3B2, 2); exp_hit('h3A3, 0);
    drain(30, "t6a_drain");
    repeat (3) step();
    check(DOUT_EE == 1'b0, "t6_no_early_ee", DOUT_EE, 0);
    do_reset(1);
    push_word(0, 0, 'h301); push_word(0, 1, 0);
    push_word(1, 0, 'h302); push_word(1, 1, 0);
    push_word(2, 1, 0);     push_word(3, 1, 0);
    exp_hit('h301, 0); exp_hit('h302, 1); exp_ee(2);
    drain(30, "t6b_drain");

    // Zero-hit event
    for (int i = 0; i < NREQ; i++) push_word(i, 1, 0);
    exp_ee(0);
    drain(30, "t7_drain");

    repeat (3) step();
    check(exp_q.size() == 0, "final_scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
